// File: rtl/dti_fifo_pkg.sv
// Shared definitions for the dual-clock gray-code FIFO pointer controllers.
// Holds the pointer-width rule and generic binary/gray conversions used by
// both the write-side and read-side controllers.
package dti_fifo_pkg;

  // Widest pointer the conversion helpers handle; narrower pointers are
  // zero-extended in and truncated out by the caller.
  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_vec_t;

  // Pointer width: one extra wrap bit above the RAM address distinguishes
  // full from empty.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Binary to reflected gray code.
  function automatic ptr_vec_t bin2gray(input ptr_vec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected gray code to binary: each bit is the XOR of all gray bits at
  // or above it. Zero-extended upper bits leave the result unaffected.
  function automatic ptr_vec_t gray2bin(input ptr_vec_t gray);
    ptr_vec_t bin;
    bin = '0;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/dti_gray2bin.sv
// Parameterized-width gray-to-binary converter (XOR prefix from the MSB).
// Shared by the write-side and read-side FIFO pointer controllers.
module dti_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Bit i of the binary value is the XOR-reduction of gray bits [WIDTH-1:i].
  always_comb begin
    // NOTE: a default before the loop guarantees every bit is assigned on
    // every evaluation, so no latch can be inferred.
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/dti_fifo_wptr_full_gf.sv
// Write-side pointer and full-flag controller for the dual-clock gray FIFO.
// Runs entirely in the write clock domain: turns pushes into a binary RAM
// address plus a registered gray write pointer for the cross-domain
// synchronizer, and derives a registered full flag from the read pointer
// synchronized back into this domain.
// Optional build macro DTI_FIFO_WPTR_AFULL_EN adds a registered occupancy
// estimate (wr_level) and almost-full flag; without it both are tied to 0.
module dti_fifo_wptr_full_gf
  import dti_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wr_push,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  wr_overflow,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  almost_full
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_full;
  logic             r_overflow;

  logic             w_push;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rptr_full_cmp;
  logic             w_full_next;

  // A push is accepted only when the FIFO is not already full.
  assign w_push = wr_en & ~r_full;

  assign w_wbin_next  = r_wbin + {{(PTR_W-1){1'b0}}, w_push};
  assign w_wgray_next = PTR_W'(bin2gray(ptr_vec_t'(w_wbin_next)));

  // Full when the write pointer has lapped the read pointer by exactly one
  // depth: in gray code that is the top two bits inverted, the rest equal.
  assign w_rptr_full_cmp = {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                            rptr_gray_sync[ADDR_WIDTH-2:0]};
  assign w_full_next     = (w_wgray_next == w_rptr_full_cmp);

  // Pointer, full flag and sticky overflow, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign waddr       = r_wbin[ADDR_WIDTH-1:0];
  assign wr_push     = w_push;
  assign wptr_gray   = r_wgray;
  assign full        = r_full;
  assign wr_overflow = r_overflow;

`ifdef DTI_FIFO_WPTR_AFULL_EN
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] r_level;
  logic             r_afull;

  dti_gray2bin #(
    .WIDTH (PTR_W)
  ) u_rptr_g2b (
    .i_gray (rptr_gray_sync),
    .o_bin  (w_rbin)
  );

  // Occupancy wraps modulo the pointer range, matching the pointer arithmetic.
  assign w_level_next = w_wbin_next - w_rbin;

  // Registered occupancy estimate and almost-full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_afull <= (w_level_next >= AFULL_LVL);
    end
  end

  assign wr_level    = r_level;
  assign almost_full = r_afull;
`else
  assign wr_level    = '0;
  assign almost_full = 1'b0;
`endif

endmodule
